// File: rtl/branch_resolve_queue_if.sv
// Bundle of the prediction, resolution, training and statistics signals
// exchanged between the branch_resolve_queue and its surroundings.
interface branch_resolve_queue_if #(
    parameter int CNT_NBITS = 32
);
    // Prediction channel: an entry transfers on a cycle where pred_val && pred_rdy;
    // pred_rdy depends only on registered occupancy, never on same-cycle inputs.
    logic                 pred_val;
    logic                 pred_rdy;
    logic [31:0]          pred_pc;
    logic                 pred_taken;
    logic                 resolve_en;
    logic                 resolve_taken;
    logic                 update_en;
    logic                 update_val;
    logic [31:0]          update_pc;
    logic                 mispredict;
    logic                 redirect_taken;
    logic [31:0]          redirect_pc;
    logic                 resolve_err;
    logic [CNT_NBITS-1:0] num_branches;
    logic [CNT_NBITS-1:0] num_mispredicts;

    modport master (
        output pred_val, pred_pc, pred_taken, resolve_en, resolve_taken,
        input  pred_rdy, update_en, update_val, update_pc, mispredict,
               redirect_taken, redirect_pc, resolve_err, num_branches, num_mispredicts
    );

    modport slave (
        input  pred_val, pred_pc, pred_taken, resolve_en, resolve_taken,
        output pred_rdy, update_en, update_val, update_pc, mispredict,
               redirect_taken, redirect_pc, resolve_err, num_branches, num_mispredicts
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of issued branch predictions; matches each resolution against
// the oldest entry, trains the predictor, flags mispredicts and squashes wrong-path entries.
module branch_resolve_queue #(
    parameter int DEPTH     = 4,
    parameter int CNT_NBITS = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_resolve_queue_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CNT_NBITS-1:0] CNT_ONE = CNT_NBITS'(1);

    logic [31:0]          pc_q    [DEPTH];
    logic                 taken_q [DEPTH];
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;

    logic                 update_en_q, update_val_q, mispredict_q;
    logic                 redirect_taken_q, resolve_err_q;
    logic [31:0]          update_pc_q, redirect_pc_q;
    logic [CNT_NBITS-1:0] num_branches_q, num_mispredicts_q;

    logic full, empty, enq, res_ok, mis;
    logic [31:0] head_pc;
    logic        head_taken;

    assign empty      = (head_q == tail_q);
    assign full       = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[PW-1] != tail_q[PW-1]);
    assign head_pc    = pc_q[head_q[IW-1:0]];
    assign head_taken = taken_q[head_q[IW-1:0]];

    assign res_ok = bus.resolve_en && !empty;
    assign mis    = res_ok && (head_taken != bus.resolve_taken);
    // A mispredict makes any same-cycle prediction wrong-path, so it is dropped.
    assign enq    = bus.pred_val && !full && !mis;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (res_ok) begin
            head_d = head_q + PTR_ONE;
        end
        if (mis) begin
            tail_d = head_q + PTR_ONE;
        end else if (enq) begin
            tail_d = tail_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            pc_q[tail_q[IW-1:0]]    <= bus.pred_pc;
            taken_q[tail_q[IW-1:0]] <= bus.pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q            <= '0;
            tail_q            <= '0;
            update_en_q       <= 1'b0;
            update_val_q      <= 1'b0;
            update_pc_q       <= '0;
            mispredict_q      <= 1'b0;
            redirect_taken_q  <= 1'b0;
            redirect_pc_q     <= '0;
            resolve_err_q     <= 1'b0;
            num_branches_q    <= '0;
            num_mispredicts_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            update_en_q  <= res_ok;
            mispredict_q <= mis;
            if (res_ok) begin
                update_val_q   <= bus.resolve_taken;
                update_pc_q    <= head_pc;
                num_branches_q <= num_branches_q + CNT_ONE;
            end
            if (mis) begin
                redirect_taken_q  <= bus.resolve_taken;
                redirect_pc_q     <= head_pc;
                num_mispredicts_q <= num_mispredicts_q + CNT_ONE;
            end
            if (bus.resolve_en && empty) begin
                resolve_err_q <= 1'b1;
            end
        end
    end

    assign bus.pred_rdy        = !full;
    assign bus.update_en       = update_en_q;
    assign bus.update_val      = update_val_q;
    assign bus.update_pc       = update_pc_q;
    assign bus.mispredict      = mispredict_q;
    assign bus.redirect_taken  = redirect_taken_q;
    assign bus.redirect_pc     = redirect_pc_q;
    assign bus.resolve_err     = resolve_err_q;
    assign bus.num_branches    = num_branches_q;
    assign bus.num_mispredicts = num_mispredicts_q;
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order tracker that sits between fetch-side prediction and execute-side branch resolution. It records every issued prediction (PC, predicted direction) in a FIFO and matches each resolved outcome against the oldest entry. It drives the predictor's training port (update_en / update_val / update PC), raises a one-cycle mispredict/flush pulse, and squashes the wrong-path younger entries. It also keeps branch and misprediction counters for the lab4_branch evaluation harness.

## Interface
- DEPTH, 4, number of in-flight predictions; power of two, ≥ 2
- CNT_NBITS, 32, width of statistics counters
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- pred_val  input  1  new prediction issued this cycle
- pred_rdy  output  1  queue can accept a prediction (not full)
- pred_pc  input  32  PC of predicted branch
- pred_taken  input  1  predicted direction (predictor `prediction` output)
- resolve_en  input  1  oldest outstanding branch resolved this cycle
- resolve_taken  input  1  actual direction
- update_en  output  1  predictor training strobe
- update_val  output  1  actual direction to train with
- update_pc  output  32  PC of trained branch (drives predictor PC during update)
- mispredict  output  1  one-cycle flush pulse
- redirect_taken  output  1  correct direction for redirect, valid with mispredict
- redirect_pc  output  32  PC of mispredicted branch, valid with mispredict
- resolve_err  output  1  sticky: resolve arrived with queue empty
- num_branches  output  CNT_NBITS  resolved branches since reset
- num_mispredicts  output  CNT_NBITS  mispredictions since reset

## Operation
- Storage: DEPTH entries of {pc[31:0], taken}; head/tail pointers of $clog2(DEPTH)+1 bits, full when indices equal and wrap bits differ, empty when equal.
- Enqueue on pred_val && pred_rdy; pred_rdy = !full (combinational from state only, independent of same-cycle dequeue).
- Resolve acts on the head entry as held at start of the cycle; a prediction enqueued in the same cycle is never the one resolved.
- Resolve with queue non-empty: dequeue head; register update_en=1, update_val=resolve_taken, update_pc=head.pc; num_branches += 1.
- If head.taken != resolve_taken: additionally mispredict=1, redirect_pc=head.pc, redirect_taken=resolve_taken, num_mispredicts += 1, queue emptied (tail := new head). A same-cycle enqueue is dropped (wrong path).
- Resolve with queue empty: no dequeue, no update, counters unchanged; resolve_err set and held until reset.
- Counters wrap modulo 2^CNT_NBITS.
- Outputs update_en, mispredict are single-cycle pulses; update_val/update_pc/redirect_* hold last value when strobes low.

## Timing
- Reset: queue empty, pred_rdy=1, update_en=0, update_val=0, update_pc=0, mispredict=0, redirect_taken=0, redirect_pc=0, resolve_err=0, both counters 0. Reset mid-operation discards all entries on that edge; enqueues/resolves in the reset cycle are ignored.
- Resolve at cycle t -> update_en/mispredict high in cycle t+1 only; counters visible in t+1.
- Enqueue at t -> pred_rdy reflects new occupancy in t+1; entry resolvable from t+1.
- Full queue with simultaneous resolve: pred_rdy=0 that cycle; slot usable from t+1.
- Back-to-back resolves every cycle supported: one update per cycle, throughput 1.
- Pointer wrap-around after DEPTH operations must not alter ordering.

## Test plan
- Reset then enqueue PC 0x100 taken=1, resolve taken=1 next cycle -> update_en=1, update_val=1, update_pc=0x100, mispredict=0, num_branches=1.
- Enqueue 0x200 (T), 0x204 (N), 0x208 (T); resolve head taken=0 -> mispredict=1, redirect_pc=0x200, redirect_taken=0, queue empty, pred_rdy=1, num_mispredicts=1; a later resolve sets resolve_err=1 with no update_en.
- Fill DEPTH=4 entries -> pred_rdy=0; pred_val held high with resolve in same cycle -> no enqueue that cycle, 5th entry accepted next cycle; resolves return PCs in order.
- Mispredict resolve concurrent with pred_val for 0x300 -> 0x300 dropped, queue empty afterward.
- Stream 10 enqueue/resolve pairs across pointer wrap with alternating outcomes -> update_pc order matches enqueue order, counters equal 10 and expected mispredict count.
- Assert reset with 3 entries queued and resolve_en high -> no update_en, counters 0, pred_rdy=1 next cycle.
